// File: rtl/mdu_ctrl_pkg.sv
// MDU controller shared definitions: op encodings, FSM state type, op-class helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // Operation encodings on the 3-bit op bus; 7 is reserved and behaves as NONE.
    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a multi-cycle count.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for the MDU (signed and unsigned).
// Latency: 0 cycles (pure combinational; the controller models the timing).
// Backpressure: none.
// Ports: op/a/b in; res_hi/res_lo out (HI/LO image of the result); div_zero flags a divide by zero.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv_ovf;
    logic [31:0] b_div;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Sign-extend to 64 bits so the low 64 bits of the product are the exact signed result.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // A zero divisor is replaced by 1 so the divider never sees it (the result is
    // discarded anyway). For the signed overflow case, dividing by 1 yields exactly
    // the architected answer: quotient 0x80000000, remainder 0.
    assign b_div = (b == 32'd0 || (op == MDU_DIV && sdiv_ovf)) ? 32'd1 : b;

    // Verilog signed division truncates toward zero; remainder follows the dividend sign.
    assign q_s = $signed(a) / $signed(b_div);
    assign r_s = $signed(a) % $signed(b_div);
    assign q_u = a / b_div;
    assign r_u = a % b_div;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
            end
            MDU_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: accepts one op per start pulse, models fixed latency, commits HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES edges from start to HI/LO update; MTHI/MTLO take one edge.
// Backpressure: delay_mdu stalls a D-stage MDU instruction while busy or on a long-op start cycle.
// Ports: clk, reset (async active-low), start/op/a/b from E stage, md_use_d from D stage;
//        busy, delay_mdu to hazard unit; hi/lo architectural registers.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        delay_mdu,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter is loaded with N-1 so the commit lands exactly N edges after start.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_hi_nxt;
    logic [31:0] pend_lo, pend_lo_nxt;
    logic        pend_dz, pend_dz_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_dz <= pend_dz_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
        end
    end

    // Starts and MTHI/MTLO are only honoured in IDLE; in RUN they are dropped silently.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_dz_nxt = pend_dz;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        pend_hi_nxt = res_hi;
                        pend_lo_nxt = res_lo;
                        pend_dz_nxt = div_zero;
                        cnt_nxt     = is_mult_op(op) ? MULT_LOAD : DIV_LOAD;
                        state_nxt   = ST_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_nxt = a;
                    end else if (op == MDU_MTLO) begin
                        lo_nxt = a;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == 4'd0) begin
                    // Divide by zero keeps the old HI/LO but still spends the full count.
                    if (!pend_dz) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // The start term covers the issue cycle so an mf* right behind a mult/div stalls.
    assign delay_mdu = md_use_d & (busy | (reset & start & is_long_op(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        delay_mdu;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .delay_mdu (delay_mdu),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        md;
        logic        pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic write_reg(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1;
        op    = o;
        a     = v;
        @(negedge clk);
        start = 1'b0;
        op    = MDU_NONE;
        a     = 32'd0;
    endtask

    // Issue a long op and follow it to commit. iop/ia optionally inject a start
    // on the second busy cycle, which the unit must ignore.
    task automatic run_long(input string nm, input logic [2:0] o, input logic [31:0] aa,
                            input logic [31:0] bb, input logic md,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic [2:0] iop, input logic [31:0] ia);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        exp_t        e;
        int          cyc;
        old_hi = hi;
        old_lo = lo;
        e.hi = ehi;
        e.lo = elo;
        e.n  = (o == MDU_MULT || o == MDU_MULTU) ? 5 : 10;
        sb.push_back(e);
        start    = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        md_use_d = md;
        #1;
        chk({nm, " delay_start"}, delay_mdu, md);
        @(negedge clk);
        start = 1'b0;
        op    = MDU_NONE;
        a     = 32'd0;
        b     = 32'd0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 40) begin
            start = 1'b0;
            op    = MDU_NONE;
            if (cyc == 2 && iop != MDU_NONE) begin
                start = 1'b1;
                op    = iop;
                a     = ia;
                b     = ia;
            end
            #1;
            chk({nm, " delay_busy"}, delay_mdu, md);
            chk({nm, " hi_hold"}, hi, old_hi);
            chk({nm, " lo_hold"}, lo, old_lo);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        op    = MDU_NONE;
        a     = 32'd0;
        b     = 32'd0;
        #1;
        chk({nm, " delay_after"}, delay_mdu, 1'b0);
        md_use_d = 1'b0;
        e = sb.pop_front();
        chk({nm, " busy_cycles"}, 64'(cyc), 64'(e.n));
        chk({nm, " hi"}, hi, e.hi);
        chk({nm, " lo"}, lo, e.lo);
    endtask

    initial begin
        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFE, 32'd3,        1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3]  = '{MDU_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 32'd0, 32'hC000_0000, 32'h8000_0000};
        vecs[4]  = '{MDU_DIVU,  32'd100,       32'd7,        1'b1, 1'b0, 32'd0, 32'd0, 32'd2,         32'd14};
        vecs[5]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{MDU_DIV,   32'd1234,      32'd0,        1'b0, 1'b1, 32'h11, 32'h22, 32'h11,        32'h22};
        vecs[8]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0,         32'h8000_0000};
        vecs[9]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,       1'b0, 1'b0, 32'd0, 32'd0, 32'hF,         32'h0FFF_FFFF};
        vecs[10] = '{MDU_DIVU,  32'd5,         32'd0,        1'b1, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 32'hAAAA_5555, 32'h1234_5678};
        vecs[11] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 32'd0, 32'h4000_0000, 32'd0};

        // Reset state, with a long-op start and md_use_d held during reset.
        reset    = 1'b0;
        start    = 1'b1;
        op       = MDU_MULT;
        a        = 32'd3;
        b        = 32'd3;
        md_use_d = 1'b1;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst delay_mdu", delay_mdu, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst busy held", busy, 1'b0);
        start    = 1'b0;
        op       = MDU_NONE;
        a        = 32'd0;
        b        = 32'd0;
        md_use_d = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre) begin
                write_reg(MDU_MTHI, vecs[i].pre_hi);
                write_reg(MDU_MTLO, vecs[i].pre_lo);
                chk($sformatf("v%0d preload hi", i), hi, vecs[i].pre_hi);
                chk($sformatf("v%0d preload lo", i), lo, vecs[i].pre_lo);
            end
            run_long($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].md,
                     vecs[i].exp_hi, vecs[i].exp_lo, MDU_NONE, 32'd0);
        end

        // NONE and the reserved encoding do nothing.
        write_reg(MDU_MTHI, 32'h0000_0055);
        write_reg(MDU_MTLO, 32'h0000_0066);
        write_reg(MDU_NONE, 32'hFFFF_FFFF);
        write_reg(3'd7, 32'hFFFF_FFFF);
        chk("nop busy", busy, 1'b0);
        chk("nop hi", hi, 32'h55);
        chk("nop lo", lo, 32'h66);

        // Reset pulsed on the third busy cycle of a divide.
        start    = 1'b1;
        op       = MDU_DIVU;
        a        = 32'd100;
        b        = 32'd7;
        md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = MDU_NONE;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort delay_mdu", delay_mdu, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort busy after", busy, 1'b0);
        chk("abort hi after", hi, 32'd0);
        chk("abort lo after", lo, 32'd0);
        chk("abort delay after", delay_mdu, 1'b0);
        md_use_d = 1'b0;

        // MTLO while busy is ignored; a second MULT start while busy is ignored too.
        run_long("mtlo_busy", MDU_MULT, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, MDU_MTLO, 32'hDEAD_BEEF);
        run_long("mult_busy", MDU_MULT, 32'd9, 32'd9, 1'b0, 32'd0, 32'd81, MDU_MULT, 32'd1000);
        run_long("div_busy",  MDU_DIVU, 32'd50, 32'd5, 1'b1, 32'd0, 32'd10, MDU_MTHI, 32'h1111_1111);
        write_reg(MDU_MTLO, 32'hDEAD_BEEF);
        chk("mtlo idle lo", lo, 32'hDEAD_BEEF);
        chk("mtlo idle hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
